// File: rtl/masked_rnd_gen_pkg.sv
// Shared definitions for the masked randomness source and the masked AND
// gadget wrappers that consume it: share/lane geometry helpers, the zero-seed
// replacement constant and the generator FSM state type.
package masked_rnd_gen_pkg;

    // Substituted for an all-zero seed word (XORed with the word index) so
    // that no xorshift32 state ever starts at its fixed point.
    localparam logic [31:0] ZERO_SEED = 32'h9E3779B9;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } rnd_state_e;

    // Fresh random bits one D-share masked AND gadget consumes per use.
    function automatic int nrnd_f(input int d);
        return d * (d - 1) / 2;
    endfunction

    // Total randomness width for LANES gadgets fed in parallel.
    function automatic int rnd_w_f(input int d, input int lanes);
        return lanes * nrnd_f(d);
    endfunction

    // Number of 32-bit xorshift words needed to cover rnd_w bits.
    function automatic int k_f(input int rnd_w);
        return (rnd_w + 31) / 32;
    endfunction

    // Counter width able to index n items, never narrower than one bit.
    function automatic int cnt_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/masked_rnd_gen_xorshift32_step.sv
// One combinational xorshift32 update (13/17/5 shift triple).
module xorshift32_step (
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [31:0] t_a;
    logic [31:0] t_b;

    assign t_a = x ^ (x << 13);
    assign t_b = t_a ^ (t_a >> 17);
    assign y   = t_b ^ (t_b << 5);

endmodule

// File: rtl/masked_rnd_gen.sv
// Randomness source for LANES masked AND gadgets with D shares. K parallel
// xorshift32 generators are seeded word by word in LOAD, then stepped once per
// consumed output in RUN. A reseed is forced after PERIOD consumed outputs
// (PERIOD = 0 disables this) or on reseed_req. All outputs come straight from
// registers so the consumer sees no combinational input-to-output path.
module masked_rnd_gen
    import masked_rnd_gen_pkg::*;
#(
    parameter int D      = 2,
    parameter int LANES  = 4,
    parameter int PERIOD = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [31:0]                      seed_in,
    input  logic                             seed_valid,
    output logic                             seed_ready,
    input  logic                             reseed_req,
    output logic [rnd_w_f(D, LANES)-1:0]     rnd,
    output logic                             rnd_valid,
    input  logic                             rnd_ready,
    output logic                             need_seed
);

    localparam int NRND   = nrnd_f(D);
    localparam int RND_W  = rnd_w_f(D, LANES);
    localparam int K      = k_f(RND_W);
    localparam int WCNT_W = cnt_w_f(K);

    localparam bit                HAS_PERIOD  = (PERIOD != 0);
    localparam logic [31:0]       PERIOD_LAST = HAS_PERIOD ? 32'(PERIOD - 1) : 32'd0;
    localparam logic [WCNT_W-1:0] WCNT_LAST   = WCNT_W'(K - 1);

    rnd_state_e        state_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic [31:0]       use_cnt_q;
    logic              seed_ready_q;
    logic              rnd_valid_q;
    logic              need_seed_q;

    logic [31:0]       s_q   [K];
    logic [31:0]       s_nxt [K];

    logic              seed_acc;
    logic              step;
    logic              last_word;
    logic              period_hit;
    logic [31:0]       seed_word;

    // A seed word lands only in LOAD and only when no restart is requested;
    // a restart in the same cycle wins and the word is dropped.
    assign seed_acc   = (state_q == ST_LOAD) && seed_ready_q && seed_valid && !reseed_req;
    // reseed_req beats a simultaneous consume: no step, no count.
    assign step       = (state_q == ST_RUN) && rnd_valid_q && rnd_ready && !reseed_req;
    assign last_word  = (wcnt_q == WCNT_LAST);
    assign period_hit = HAS_PERIOD && (use_cnt_q == PERIOD_LAST);
    assign seed_word  = (seed_in == 32'd0) ? (ZERO_SEED ^ 32'(wcnt_q)) : seed_in;

    // One single-step update per state word, used only on a consume.
    for (genvar i = 0; i < K; i++) begin : g_step
        xorshift32_step u_step (
            .x (s_q[i]),
            .y (s_nxt[i])
        );
    end

    // rnd is the low RND_W bits of {S[K-1],...,S[0]}; the top word may be partial.
    for (genvar i = 0; i < K; i++) begin : g_rnd
        if ((i + 1) * 32 <= RND_W) begin : g_full
            assign rnd[i*32 +: 32] = s_q[i];
        end else begin : g_part
            assign rnd[RND_W-1:i*32] = s_q[i][RND_W-1-i*32:0];
        end
    end

    assign seed_ready = seed_ready_q;
    assign rnd_valid  = rnd_valid_q;
    assign need_seed  = need_seed_q;

    // Generator state words: loaded one per accepted seed, stepped per consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K; i++) begin
                s_q[i] <= '0;
            end
        end else if (seed_acc) begin
            for (int i = 0; i < K; i++) begin
                if (wcnt_q == WCNT_W'(i)) begin
                    s_q[i] <= seed_word;
                end
            end
        end else if (step) begin
            for (int i = 0; i < K; i++) begin
                s_q[i] <= s_nxt[i];
            end
        end
    end

    // LOAD/RUN sequencing with seed word index, usage count and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            wcnt_q       <= '0;
            use_cnt_q    <= '0;
            seed_ready_q <= 1'b1;
            rnd_valid_q  <= 1'b0;
            need_seed_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (reseed_req) begin
                        wcnt_q <= '0;
                    end else if (seed_acc) begin
                        if (last_word) begin
                            state_q      <= ST_RUN;
                            wcnt_q       <= '0;
                            use_cnt_q    <= '0;
                            seed_ready_q <= 1'b0;
                            rnd_valid_q  <= 1'b1;
                            need_seed_q  <= 1'b0;
                        end else begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (reseed_req || (step && period_hit)) begin
                        state_q      <= ST_LOAD;
                        wcnt_q       <= '0;
                        seed_ready_q <= 1'b1;
                        rnd_valid_q  <= 1'b0;
                        need_seed_q  <= 1'b1;
                    end
                    if (step) begin
                        use_cnt_q <= use_cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_q      <= ST_LOAD;
                    wcnt_q       <= '0;
                    seed_ready_q <= 1'b1;
                    rnd_valid_q  <= 1'b0;
                    need_seed_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_rnd_gen.sv
// Bench for masked_rnd_gen: three configurations (full 32-bit view, PERIOD=3,
// two-word K=2). Expected rnd values are queued when a consume is planned and
// checked by per-instance monitors at every handshake.
module tb_masked_rnd_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: D=2, LANES=32 -> RND_W=32, K=1, rnd shows S[0] in full
    logic        rst_n_a, a_seed_valid, a_seed_ready, a_reseed, a_rnd_valid, a_rnd_ready, a_need_seed;
    logic [31:0] a_seed_in, a_rnd;
    // Instance B: D=2, LANES=4, PERIOD=3 -> RND_W=4, K=1
    logic        rst_n_b, b_seed_valid, b_seed_ready, b_reseed, b_rnd_valid, b_rnd_ready, b_need_seed;
    logic [31:0] b_seed_in;
    logic [3:0]  b_rnd;
    // Instance C: D=3, LANES=12 -> RND_W=36, K=2
    logic        rst_n_c, c_seed_valid, c_seed_ready, c_reseed, c_rnd_valid, c_rnd_ready, c_need_seed;
    logic [31:0] c_seed_in;
    logic [35:0] c_rnd;

    logic [31:0] q_a[$];
    logic [3:0]  q_b[$];
    logic [35:0] q_c[$];

    masked_rnd_gen #(.D(2), .LANES(32), .PERIOD(1024)) u_a (
        .clk(clk), .rst_n(rst_n_a), .seed_in(a_seed_in), .seed_valid(a_seed_valid),
        .seed_ready(a_seed_ready), .reseed_req(a_reseed), .rnd(a_rnd),
        .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready), .need_seed(a_need_seed)
    );

    masked_rnd_gen #(.D(2), .LANES(4), .PERIOD(3)) u_b (
        .clk(clk), .rst_n(rst_n_b), .seed_in(b_seed_in), .seed_valid(b_seed_valid),
        .seed_ready(b_seed_ready), .reseed_req(b_reseed), .rnd(b_rnd),
        .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready), .need_seed(b_need_seed)
    );

    masked_rnd_gen #(.D(3), .LANES(12), .PERIOD(0)) u_c (
        .clk(clk), .rst_n(rst_n_c), .seed_in(c_seed_in), .seed_valid(c_seed_valid),
        .seed_ready(c_seed_ready), .reseed_req(c_reseed), .rnd(c_rnd),
        .rnd_valid(c_rnd_valid), .rnd_ready(c_rnd_ready), .need_seed(c_need_seed)
    );

    // Reference xorshift32 step (13/17/5), used for values past the hand-derived ones
    function automatic logic [31:0] xs_ref(input logic [31:0] v);
        logic [31:0] x;
        x = v;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a handshake is valid&ready without a reseed in the same cycle
    always @(negedge clk) begin
        if (rst_n_a && a_rnd_valid && a_rnd_ready && !a_reseed) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_hs: got %0h expected no handshake", a_rnd);
            end else chk("a_hs_rnd", 64'(a_rnd), 64'(q_a.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n_b && b_rnd_valid && b_rnd_ready && !b_reseed) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_hs: got %0h expected no handshake", b_rnd);
            end else chk("b_hs_rnd", 64'(b_rnd), 64'(q_b.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (rst_n_c && c_rnd_valid && c_rnd_ready && !c_reseed) begin
            if (q_c.size() == 0) begin
                total++; bad++;
                $display("FAIL c_unexpected_hs: got %0h expected no handshake", c_rnd);
            end else chk("c_hs_rnd", 64'(c_rnd), 64'(q_c.pop_front()));
        end
    end

    logic [31:0] hold;

    initial begin
        rst_n_a = 0; rst_n_b = 0; rst_n_c = 0;
        a_seed_in = 0; a_seed_valid = 0; a_reseed = 0; a_rnd_ready = 0;
        b_seed_in = 0; b_seed_valid = 0; b_reseed = 0; b_rnd_ready = 0;
        c_seed_in = 0; c_seed_valid = 0; c_reseed = 0; c_rnd_ready = 0;
        tick(); tick();

        // ---- reset state
        chk("rst_rnd_valid", 64'(a_rnd_valid), 64'd0);
        chk("rst_seed_ready", 64'(a_seed_ready), 64'd1);
        chk("rst_need_seed", 64'(a_need_seed), 64'd1);
        chk("rst_rnd", 64'(a_rnd), 64'd0);
        rst_n_a = 1; rst_n_b = 1; rst_n_c = 1;
        tick();

        // ---- A: seed 1, three consumes, stall, reseed priority, zero seed
        a_seed_in = 32'h00000001; a_seed_valid = 1;
        tick();
        a_seed_valid = 0;
        chk("a_seed1_valid", 64'(a_rnd_valid), 64'd1);
        chk("a_seed1_rnd", 64'(a_rnd), 64'h1);
        chk("a_seed1_need", 64'(a_need_seed), 64'd0);
        chk("a_seed1_sready", 64'(a_seed_ready), 64'd0);
        q_a.push_back(32'h00000001);
        q_a.push_back(32'h00042021);
        q_a.push_back(32'h04080601);
        a_rnd_ready = 1;
        tick(); tick(); tick();
        a_rnd_ready = 0;
        hold = xs_ref(32'h04080601);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("a_stall_rnd", 64'(a_rnd), 64'(hold));
            chk("a_stall_valid", 64'(a_rnd_valid), 64'd1);
        end
        a_reseed = 1; a_rnd_ready = 1;
        tick();
        a_reseed = 0; a_rnd_ready = 0;
        chk("a_reseed_need", 64'(a_need_seed), 64'd1);
        chk("a_reseed_valid", 64'(a_rnd_valid), 64'd0);
        chk("a_reseed_sready", 64'(a_seed_ready), 64'd1);
        chk("a_reseed_nostep", 64'(a_rnd), 64'(hold));
        a_seed_in = 32'h00000000; a_seed_valid = 1;
        tick();
        a_seed_valid = 0;
        chk("a_zero_seed_rnd", 64'(a_rnd), 64'h9E3779B9);
        chk("a_zero_seed_need", 64'(a_need_seed), 64'd0);
        q_a.push_back(32'h9E3779B9);
        a_rnd_ready = 1;
        tick();
        a_rnd_ready = 0;
        chk("a_zero_step", 64'(a_rnd), 64'(xs_ref(32'h9E3779B9)));

        // ---- B: PERIOD=3 with a stall in the middle
        b_seed_in = 32'h00000001; b_seed_valid = 1;
        tick();
        b_seed_valid = 0;
        chk("b_seed1_rnd", 64'(b_rnd), 64'h1);
        q_b.push_back(4'h1);
        b_rnd_ready = 1;
        tick();
        b_rnd_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_stall_rnd", 64'(b_rnd), 64'h1);
            chk("b_stall_valid", 64'(b_rnd_valid), 64'd1);
        end
        q_b.push_back(4'h1);
        q_b.push_back(4'h1);
        b_rnd_ready = 1;
        tick(); tick();
        chk("b_period_valid", 64'(b_rnd_valid), 64'd0);
        chk("b_period_need", 64'(b_need_seed), 64'd1);
        chk("b_period_sready", 64'(b_seed_ready), 64'd1);
        tick(); tick();
        b_rnd_ready = 0;
        chk("b_period_stays_load", 64'(b_need_seed), 64'd1);
        chk("b_last_hs_stepped", 64'(b_rnd), 64'(xs_ref(32'h04080601) & 32'hF));
        b_seed_in = 32'h00000000; b_seed_valid = 1;
        tick();
        b_seed_valid = 0;
        chk("b_zero_seed_rnd", 64'(b_rnd), 64'h9);
        chk("b_zero_seed_need", 64'(b_need_seed), 64'd0);

        // ---- C: K=2, reset mid-load discards the partial seed
        c_seed_in = 32'h11111111; c_seed_valid = 1;
        tick();
        c_seed_valid = 0;
        rst_n_c = 0;
        #1;
        chk("c_rst_need", 64'(c_need_seed), 64'd1);
        chk("c_rst_valid", 64'(c_rnd_valid), 64'd0);
        chk("c_rst_rnd", 64'(c_rnd), 64'd0);
        tick();
        rst_n_c = 1;
        tick();
        c_seed_in = 32'hAAAAAAAA; c_seed_valid = 1;
        tick();
        c_seed_valid = 0;
        chk("c_one_word_valid", 64'(c_rnd_valid), 64'd0);
        chk("c_one_word_need", 64'(c_need_seed), 64'd1);
        c_seed_in = 32'h00000000; c_seed_valid = 1;
        tick();
        c_seed_valid = 0;
        chk("c_two_word_valid", 64'(c_rnd_valid), 64'd1);
        chk("c_two_word_rnd", 64'(c_rnd), 64'h8AAAAAAAA);
        q_c.push_back(36'h8AAAAAAAA);
        c_rnd_ready = 1;
        tick();
        c_rnd_ready = 0;
        chk("c_step_rnd", 64'(c_rnd),
            64'({xs_ref(32'h9E3779B8) & 32'hF, xs_ref(32'hAAAAAAAA)}));

        tick(); tick();
        chk("a_queue_drained", 64'(q_a.size()), 64'd0);
        chk("b_queue_drained", 64'(q_b.size()), 64'd0);
        chk("c_queue_drained", 64'(q_c.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/masked_rnd_gen.md
MASKED_RND_GEN -- requirements
Module: masked_rnd_gen

Interface
REQ-001 SHALL have parameter D, default 2, share count of the downstream masked AND gadgets.
REQ-002 SHALL have parameter LANES, default 4, number of masked AND gadgets fed in parallel.
REQ-003 SHALL have parameter PERIOD, default 1024, consumed outputs between mandatory reseeds; 0 = never reseed.
REQ-004 SHALL derive localparams NRND = D*(D-1)/2, RND_W = LANES*NRND and K = ceil(RND_W/32).
REQ-005 SHALL have port clk, input, 1, single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port seed_in, input, 32, seed word.
REQ-008 SHALL have port seed_valid, input, 1, seed word present.
REQ-009 SHALL have port seed_ready, output, 1, seed word accepted this cycle.
REQ-010 SHALL have port reseed_req, input, 1, forces return to seed loading.
REQ-011 SHALL have port rnd, output, RND_W, fresh randomness; lane g occupies bits [g*NRND +: NRND] in gadget triangular ordering.
REQ-012 SHALL have port rnd_valid, output, 1, rnd holds an unconsumed value.
REQ-013 SHALL have port rnd_ready, input, 1, consumer takes rnd this cycle.
REQ-014 SHALL have port need_seed, output, 1, high while in LOAD.

Function
REQ-015 SHALL hold K 32-bit xorshift32 states S[0..K-1]; rnd = low RND_W bits of {S[K-1],...,S[0]}.
REQ-016 SHALL implement FSM with two states: LOAD (seed_ready=1, rnd_valid=0, need_seed=1) and RUN (seed_ready=0, rnd_valid=1, need_seed=0).
REQ-017 SHALL, in LOAD, write seed_in into S[wcnt] on each seed_valid&seed_ready and increment wcnt (width ceil(log2 K), min 1).
REQ-018 SHALL substitute 32'h9E3779B9 ^ index for a zero seed word, so no state is ever zero.
REQ-019 SHALL move LOAD->RUN on the cycle the word for index K-1 is accepted, clearing wcnt and the usage counter; rnd_valid rises the next cycle.
REQ-020 SHALL, in RUN on rnd_valid&rnd_ready, step every S[i] by x^=x<<13; x^=x>>17; x^=x<<5 and increment the 32-bit usage counter.
REQ-021 SHALL hold rnd and all states stable while rnd_valid&~rnd_ready.
REQ-022 SHALL move RUN->LOAD when PERIOD!=0 and a handshake occurs with usage counter == PERIOD-1; that handshake still steps the states.
REQ-023 SHALL move RUN->LOAD on reseed_req, which takes priority over a simultaneous handshake (no step, no count); reseed_req in LOAD restarts wcnt at 0.
REQ-024 SHALL never present the same rnd value for two handshakes without a state step in between (consumer registers rnd internally as its previous-cycle copy).
REQ-025 SHALL have zero combinational paths from inputs to outputs; all outputs are registered or decoded from the state register.

Reset
REQ-026 SHALL, on rst_n low, asynchronously enter LOAD with wcnt=0, usage counter=0, all S[i]=0, rnd=0, rnd_valid=0, seed_ready=1, need_seed=1.
REQ-027 SHALL treat reset during RUN or mid-LOAD identically; partial seeds are discarded.

Structure
REQ-028 SHALL place NRND/RND_W/K derivation functions and the zero-seed constant in a shared package also used by the masked gadget wrappers.
REQ-029 SHALL use one sub-module, xorshift32_step, purely combinational single-step update, instantiated K times.

Verification
REQ-030 D=2, LANES=4 (K=1): reset, seed 32'h00000001 -> next cycle rnd_valid=1, rnd=4'h1; one handshake -> S[0]=32'h00042021, rnd=4'h1.
REQ-031 Seed 32'h00000000 -> S[0]=32'h9E3779B9, rnd=4'h9, need_seed=0.
REQ-032 PERIOD=3, rnd_ready held 1 -> exactly 3 handshakes, then rnd_valid=0, need_seed=1, seed_ready=1.
REQ-033 rnd_ready=0 for 5 cycles in RUN -> rnd unchanged, usage counter unchanged.
REQ-034 reseed_req and rnd_ready both high in RUN -> LOAD entered, state not stepped, counter not incremented.
REQ-035 D=3, LANES=12 (RND_W=36, K=2): rst_n asserted after one seed word -> LOAD with wcnt=0; two fresh words required before rnd_valid=1.
